// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each word is issued, confirmed via wr_ack, and retried on overflow up to MAX_RETRY times.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned MAX_RETRY  = 3,
  parameter bit          USE_AF     = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            drop,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          wr_ack,
  input  logic                          overflow
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, BACKOFF} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     idx;
  logic [RETRY_W-1:0]   retry_cnt;

  logic [IDX_W-1:0]      win_idx_c;
  logic                  win_vld_c;
  logic [FIFO_WIDTH-1:0] win_data_c;
  logic                  can_issue_c;
  logic [IDX_W-1:0]      next_ptr_c;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    win_idx_c = '0;
    win_vld_c = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand     = (32'(rr_ptr) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_vld_c && req[cand_idx]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand_idx;
      end
    end
  end

  assign win_data_c  = req_data[32'(win_idx_c)*FIFO_WIDTH +: FIFO_WIDTH];
  assign can_issue_c = win_vld_c && !full && !(USE_AF && almostfull);
  assign next_ptr_c  = (32'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      idx       <= '0;
      retry_cnt <= '0;
      gnt       <= '0;
      drop      <= '0;
      wr_en     <= 1'b0;
      data_in   <= '0;
    end else begin
      gnt   <= '0;
      drop  <= '0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (can_issue_c) begin
            idx       <= win_idx_c;
            data_in   <= win_data_c;
            wr_en     <= 1'b1;
            retry_cnt <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // A missing response is treated like an overflow so the word is never lost silently.
          if (wr_ack) begin
            gnt[idx] <= 1'b1;
            rr_ptr   <= next_ptr_c;
            state    <= IDLE;
          end else if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
            drop[idx] <= 1'b1;
            rr_ptr    <= next_ptr_c;
            state     <= IDLE;
          end else begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
            state     <= BACKOFF;
          end
        end
        BACKOFF: begin
          if (!full) begin
            wr_en <= 1'b1;
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
